multicycle_controller: RTL and testbench

Moore-style control FSM that sequences the shared multicycle RV32I datapath: one unified instruction/data memory, one ALU, and the IR, OldPC, A, ALUOut and Data registers.
- Each instruction takes 3–5 cycles: fetch, decode, then an op-specific path.
- Drives every datapath mux select and write enable, plus ALU function decode.
- Sits beside the datapath, replacing the single-cycle combinational controller for the multicycle core.

---
 rtl/multicycle_controller.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Purpose : Moore control FSM sequencing the shared multicycle RV32I datapath (IR, OldPC, A, ALUOut, Data).
// Latency : beq 3 cycles; R-type, I-type, sw and jal 4 cycles; lw 5 cycles (no stalls).
// Backpres: with MEM_STALL_EN, FETCH/MEMREAD/MEMWRITE hold while MemReady=0; without it, MemReady is ignored.
//
// Optional feature macro: MEM_STALL_EN (memory-ready stall handshake). Undefined by default.
//
// Ports:
//   clk, reset_n           core clock (rising edge), asynchronous active-low reset
//   op, funct3, funct7b5   instruction fields IR[6:0], IR[14:12], IR[30]
//   Zero                   ALU zero flag, qualifies branches
//   MemReady               memory access completes this cycle (only used with MEM_STALL_EN)
//   PCWrite, IRWrite       PC enable, IR/OldPC enable
//   AdrSrc                 memory address select: 0=PC, 1=Result
//   MemWrite, RegWrite     memory write strobe, register file write enable
//   ResultSrc              00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA, ALUSrcB       A: 00=PC, 01=OldPC, 10=A ; B: 00=rs2, 01=ImmExt, 10=const 4
//   ImmSrc                 00=I, 01=S, 10=B, 11=J (decoded from op)
//   ALUControl             000 add, 001 sub, 010 and, 011 or, 101 slt
//   IllegalOp              sticky: an unsupported opcode reached DECODE; cleared only by reset

module multicycle_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       RegWrite,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // Memory handshake: when stalls are compiled out every access completes in one cycle.
`ifdef MEM_STALL_EN
    logic mem_ready;
    assign mem_ready = MemReady;
`else
    logic mem_ready;
    logic unused_memready;
    assign mem_ready       = 1'b1;
    assign unused_memready = MemReady;
`endif

    state_t     state;
    state_t     state_nxt;
    logic       pc_update;
    logic       branch;
    logic [1:0] alu_op;
    logic [1:0] imm_dec;
    logic       op_supported;
    logic       illegal_set;

    // Opcode classification used both for DECODE dispatch and the sticky illegal flag.
    always_comb begin
        op_supported = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: op_supported = 1'b1;
            default:                                               op_supported = 1'b0;
        endcase
    end

    assign illegal_set = (state == DECODE) && !op_supported;

    // Immediate format follows the opcode regardless of state so ImmExt is ready early.
    always_comb begin
        imm_dec = 2'b00;
        case (op)
            OP_STORE: imm_dec = 2'b01;
            OP_BEQ:   imm_dec = 2'b10;
            OP_JAL:   imm_dec = 2'b11;
            default:  imm_dec = 2'b00;
        endcase
    end

    // State register and sticky illegal-op flag; reset clears both without waiting for clk.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= state_t'(RESET_STATE);
            IllegalOp <= 1'b0;
        end else begin
            state <= state_nxt;
            if (illegal_set) begin
                IllegalOp <= 1'b1;
            end
        end
    end

    // Moore decode: outputs depend on state only, with Zero (branch) and mem_ready (stall)
    // as the two qualifying inputs. Anything not named for a state stays 0.
    always_comb begin
        state_nxt = FETCH;
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = 2'b00;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ImmSrc    = imm_dec;
        RegWrite  = 1'b0;

        case (state)
            FETCH: begin
                // Selects stay put during a stall; only the enables wait for the access.
                AdrSrc    = 1'b0;
                IRWrite   = mem_ready;
                ALUSrcA   = 2'b00;
                ALUSrcB   = 2'b10;
                alu_op    = 2'b00;
                ResultSrc = 2'b10;
                pc_update = mem_ready;
                state_nxt = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                alu_op  = 2'b00;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_RTYPE:          state_nxt = EXECUTER;
                    OP_ITYPE:          state_nxt = EXECUTEI;
                    OP_JAL:            state_nxt = JAL;
                    OP_BEQ:            state_nxt = BEQ;
                    default:           state_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                alu_op    = 2'b00;
                state_nxt = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                ResultSrc = 2'b00;
                AdrSrc    = 1'b1;
                state_nxt = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            MEMWRITE: begin
                // Strobe is held for every stall cycle; the memory samples it on MemReady.
                ResultSrc = 2'b00;
                AdrSrc    = 1'b1;
                MemWrite  = 1'b1;
                state_nxt = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTER: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                alu_op    = 2'b10;
                state_nxt = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                alu_op    = 2'b10;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                RegWrite  = 1'b1;
                state_nxt = FETCH;
            end
            JAL: begin
                // PC <- ALUOut (target) while ALU computes OldPC+4 for the link register.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                alu_op    = 2'b00;
                ResultSrc = 2'b00;
                pc_update = 1'b1;
                state_nxt = ALUWB;
            end
            BEQ: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b00;
                alu_op    = 2'b01;
                ResultSrc = 2'b00;
                branch    = 1'b1;
                state_nxt = FETCH;
            end
            default: begin
                // Unreachable encodings: fully quiet, including the immediate select.
                ImmSrc    = 2'b00;
                state_nxt = FETCH;
            end
        endcase
    end

    assign PCWrite = pc_update | (branch & Zero);

    // ALU function decode. op[5] separates R-type (sub possible) from I-type (addi only).
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b1;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    multicycle_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .RegWrite(RegWrite),
        .IllegalOp(IllegalOp)
    );

    always #5 clk = ~clk;

`ifdef MEM_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic ill_model = 1'b0;
    int   force_stall = 0;

    function automatic int kind_of(input logic [6:0] o);
        case (o)
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return K_BEQ;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int ilen(input int k);
        case (k)
            K_LW:    return 5;
            K_BEQ:   return 3;
            K_ILL:   return 2;
            default: return 4;
        endcase
    endfunction

    // Steps that touch memory: the fetch, and the data access of lw/sw.
    function automatic bit is_mem_step(input int k, input int step);
        return (step == 0) || ((k == K_LW || k == K_SW) && step == 3);
    endfunction

    // Arithmetic an R/I instruction asks for, by mnemonic.
    function automatic logic [2:0] arith(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected output word for step 'step' of an instruction of class k.
    // Packing: {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,ALUControl,RegWrite,IllegalOp}
    function automatic logic [16:0] exp_out(input int k, input int step, input logic [6:0] o,
                                            input logic [2:0] f3, input logic f7, input logic z,
                                            input logic rdy, input logic ill);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] ac;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
        rs = 0; sa = 0; sb = 0; ac = 0;
        imm = (k == K_SW) ? 2'b01 : (k == K_BEQ) ? 2'b10 : (k == K_JAL) ? 2'b11 : 2'b00;
        if (step == 0) begin
            irw = rdy; pcw = rdy; rs = 2'b10; sb = 2'b10;
        end else if (step == 1) begin
            sa = 2'b01; sb = 2'b01;
        end else begin
            case (k)
                K_R: if (step == 2) begin sa = 2'b10; ac = arith(o, f3, f7); end else rw = 1;
                K_I: if (step == 2) begin sa = 2'b10; sb = 2'b01; ac = arith(o, f3, f7); end else rw = 1;
                K_LW: begin
                    if (step == 2) begin sa = 2'b10; sb = 2'b01; end
                    else if (step == 3) adr = 1;
                    else begin rs = 2'b01; rw = 1; end
                end
                K_SW: if (step == 2) begin sa = 2'b10; sb = 2'b01; end else begin adr = 1; mw = 1; end
                K_BEQ: begin sa = 2'b10; ac = 3'b001; pcw = z; end
                K_JAL: if (step == 2) begin sa = 2'b01; sb = 2'b10; pcw = 1; end else rw = 1;
                default: ;
            endcase
        end
        return {pcw, adr, mw, irw, rs, sa, sb, imm, ac, rw, ill};
    endfunction

    // Execute one instruction from FETCH, checking every cycle. Entered and left at a negedge.
    // abort_step >= 0 pulls reset asynchronously in that step and checks the immediate FETCH decode.
    task automatic run_instr(input string name, input logic [31:0] ir, input logic zv, input int abort_step);
        int k, step, stalls, guard;
        logic [16:0] exp_v, obs;
        bit adv;
        op = ir[6:0]; funct3 = ir[14:12]; funct7b5 = ir[30];
        k = kind_of(ir[6:0]);
        step = 0; stalls = 0; guard = 0;
        while (step < ilen(k)) begin
            Zero = zv;
            if (STALL && is_mem_step(k, step)) begin
                if (force_stall > 0) MemReady = (stalls >= force_stall);
                else MemReady = (stalls >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            end else begin
                MemReady = 1'($urandom_range(0, 1));
            end
            #1;
            exp_v = exp_out(k, step, ir[6:0], ir[14:12], ir[30], zv, !STALL || MemReady, ill_model);
            obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                   ALUControl, RegWrite, IllegalOp};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL %s step %0d: got %b want %b", name, step, obs, exp_v);
            end
            if (step == abort_step) begin
                #2 reset_n = 1'b0;
                MemReady = 1'b1;
                #1;
                ill_model = 1'b0;
                exp_v = exp_out(k, 0, ir[6:0], ir[14:12], ir[30], zv, 1'b1, 1'b0);
                obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                       ALUControl, RegWrite, IllegalOp};
                n_cmp++;
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL %s async_reset: got %b want %b", name, obs, exp_v);
                end
                @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            adv = !(STALL && is_mem_step(k, step) && !MemReady);
            stalls = adv ? 0 : stalls + 1;
            @(posedge clk);
            if (adv) begin
                if (k == K_ILL && step == 1) ill_model = 1'b1;
                step++;
            end
            guard++;
            if (guard > 64) begin
                n_bad++;
                $display("FAIL %s timeout: got step %0d want done", name, step);
                step = 99;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [16:0] exp_v, obs;
        reset_n = 1'b0; MemReady = 1'b1;
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            exp_v = exp_out(K_R, 0, op, funct3, funct7b5, 1'b0, 1'b1, 1'b0);
            obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                   ALUControl, RegWrite, IllegalOp};
            n_cmp++;
            if (obs !== exp_v) begin
                n_bad++;
                $display("FAIL reset_state: got %b want %b", obs, exp_v);
            end
            @(posedge clk);
        end
        @(negedge clk);
        reset_n = 1'b1;
        ill_model = 1'b0;
    endtask

    task automatic test_alu_ops();
        run_instr("add", 32'h002081B3, 1'b0, -1);
        run_instr("sub", 32'h402081B3, 1'b0, -1);
        run_instr("ori", 32'h0010E193, 1'b0, -1);
        run_instr("slt", 32'h0020A1B3, 1'b0, -1);
        run_instr("and", 32'h0020F1B3, 1'b0, -1);
        run_instr("addi_f7", 32'h40008193, 1'b0, -1);
    endtask

    task automatic test_load_store();
        run_instr("lw", 32'h0000A183, 1'b0, -1);
        run_instr("sw", 32'h0030A023, 1'b0, -1);
    endtask

    task automatic test_branch_jump();
        run_instr("beq_taken", 32'h00208463, 1'b1, -1);
        run_instr("beq_not", 32'h00208463, 1'b0, -1);
        run_instr("jal", 32'h008000EF, 1'b0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 32'h00000000, 1'b0, -1);
        run_instr("add_after_ill", 32'h002081B3, 1'b0, -1);
        run_instr("lw_after_ill", 32'h0000A183, 1'b0, -1);
    endtask

    task automatic test_async_reset();
        run_instr("illegal_pre", 32'h00000000, 1'b0, -1);
        run_instr("lw_abort", 32'h0000A183, 1'b0, 3);
        run_instr("add_post_reset", 32'h002081B3, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [7];
        logic [6:0] bad [5];
        logic [31:0] ir;
        int pick;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0};
        bad = '{7'b0110111, 7'b0010111, 7'b1100111, 7'b1110011, 7'b1111111};
        for (int n = 0; n < 120; n++) begin
            ir = $urandom;
            pick = $urandom_range(0, 6);
            ir[6:0] = (pick == 6) ? bad[$urandom_range(0, 4)] : ops[pick];
            run_instr("random", ir, 1'($urandom_range(0, 1)), -1);
        end
    endtask

`ifdef MEM_STALL_EN
    task automatic test_stall();
        force_stall = 3;
        run_instr("stall_add", 32'h002081B3, 1'b0, -1);
        run_instr("stall_sw", 32'h0030A023, 1'b0, -1);
        run_instr("stall_lw", 32'h0000A183, 1'b0, -1);
        force_stall = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_load_store();
        test_branch_jump();
        test_illegal();
        test_async_reset();
`ifdef MEM_STALL_EN
        test_stall();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
